sokoban_board_engine: RTL and testbench
=======================================

Name: sokoban_board_engine

Overview:
- Parametrised successor to the fixed 8x8 Sokoban game core: grid of GRID_W x GRID_H cells, a multi-level undo history, and a valid/ready command interface.
- Sits between the ps2 command decoder and the display.
- Holds live board state, loads levels from an external level ROM indexed by stage, executes moves/pushes, tracks steps and win.

Parameters:
- GRID_W, 8, grid columns.
- GRID_H, 8, grid rows. CELLS = GRID_W*GRID_H; POS_W = clog2(CELLS). Cell index = row*GRID_W + col.
- UNDO_DEPTH, 16, undo records held (circular; oldest overwritten).
- STEP_W, 8, step counter width.
- STAGE_W, 2, stage index width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept command
- cmd_op  in  3  0 up, 1 down, 2 left, 3 right, 4 undo, 5 retry, 6 next_stage, 7 prev_stage
- lvl_wall  in  CELLS  ROM wall bitmap for current stage
- lvl_box  in  CELLS  ROM box bitmap
- lvl_dest  in  CELLS  ROM destination bitmap
- lvl_man  in  POS_W  ROM start position
- wall  out  CELLS  live wall bitmap
- box  out  CELLS  live box bitmap
- destination  out  CELLS  live destination bitmap
- man  out  POS_W  live man position
- stage  out  STAGE_W  current stage
- step  out  STEP_W  step count
- undo_count  out  clog2(UNDO_DEPTH+1)  undo records available
- win  out  1  all boxes on destinations

Behaviour:
- Reset (sync, active-high, clk rising edge):
  - stage=0, step=0, undo_count=0, win=0; all bitmaps 0, man=0; cmd_ready=0.
  - FSM enters LOAD_A.
- FSM states:
  - LOAD_A: one cycle; ROM address (stage) settles.
  - LOAD_B: captures lvl_*; step=0; undo_count=0; win=0 → IDLE.
  - IDLE: cmd_ready=1. Handshake on cmd_valid&cmd_ready latches cmd_op → EXEC.
  - EXEC: one cycle; applies the command; cmd_ready=0.
    - After a move or undo → CHECK.
    - After retry, next_stage or prev_stage → LOAD_A.
  - CHECK: one cycle; win <= ((box & ~destination)==0) && (box!=0) → WIN if set, else IDLE.
  - WIN: cmd_ready=1. Moves and undo are accepted and discarded; retry, next_stage and prev_stage proceed via EXEC.
- Latency:
  - Move visible on outputs 1 cycle after handshake; win valid 2 cycles after.
  - Level load completes 3 cycles after handshake.
- Move rules (dir d; target t = man+d; beyond u = t+d):
  - If t is outside the grid (row/col edge check, no index wrap) or wall[t]: blocked.
  - If box[t]: blocked if u is outside the grid, wall[u] or box[u]; otherwise box[t]<=0, box[u]<=1, man<=t.
  - Otherwise man<=t.
  - Successful move: step += 1, saturating at 2^STEP_W-1. Push undo record {prev man, d, pushed}.
  - Blocked move: command consumed; no state change, no record.
- Undo:
  - If undo_count=0, no-op.
  - Otherwise pop the newest record:
    - man <= prev.
    - If pushed: box at man_cur+d returns to man_cur.
    - step -= 1, saturating at 0.
- Undo buffer:
  - Push when full overwrites the oldest record; undo_count stays UNDO_DEPTH.
  - A push and a pop never occur in the same cycle.
- Stage:
  - next_stage/prev_stage wrap modulo 2^STAGE_W.
  - retry reloads the current stage.
  - All three clear step and the undo history.
- Reset mid-operation (any state): immediate return to the reset values; any in-flight command is dropped.

Optional Feature:
- Macro: SOKOBAN_UNDO_EN.
- Defined: undo buffer instantiated; behaviour as above.
- Undefined:
  - No buffer storage.
  - op 4 consumed as a no-op (EXEC → IDLE/WIN without board change).
  - undo_count tied to 0.

Decomposition:
- Package sokoban_pkg:
  - op code constants.
  - direction encoding.
  - FSM state enum (LOAD_A, LOAD_B, IDLE, EXEC, CHECK, WIN).
  - undo record typedef {prev_pos, dir[1:0], pushed}.
  - position/neighbour helper functions taking GRID_W/GRID_H.
- Sub-module sokoban_undo_stack: circular LIFO, overwrite-oldest, depth UNDO_DEPTH, ports push/pop/rec_in/rec_out/count.

Test Plan:
- Reset, ROM with man=9, box bit 10, dest bit 11 → after 3 cycles man=9, box=1<<10, step=0, win=0, cmd_ready=1.
- Same level, right → man=10, box=1<<11, step=1; win=1 two cycles after handshake; a following up is consumed with man unchanged.
- man=9, wall bit 10, right → blocked: man=9, step=0, undo_count=0.
- man=9, box at 10 and 11, right → blocked. man=0, left → blocked (edge, no wrap to 63).
- Push box 10→11, then undo → man=9, box=1<<10, step=0, undo_count=0. 20 legal moves with UNDO_DEPTH=16 → undo_count=16; 17th undo is a no-op.
- stage=3, next_stage → stage=0, board reloaded, step=0. Reset asserted during EXEC → reset values next cycle.

Source files
------------

// File: rtl/sokoban_pkg.sv
// rtl/sokoban_pkg.sv - shared constants, FSM states, undo record and grid helpers
//
// Purpose: definitions shared by sokoban_board_engine and sokoban_undo_stack.
//   - command op codes (cmd_op encoding)
//   - direction encoding (equal to the low two bits of the move op codes)
//   - FSM state enum
//   - undo record layout {prev_pos, dir, pushed}
//   - grid neighbour / edge helpers parameterised by grid width and height
// Ports: none (package).
// Optional feature macro used by the engine: SOKOBAN_UNDO_EN.
package sokoban_pkg;

  localparam logic [2:0] OP_UP    = 3'd0;
  localparam logic [2:0] OP_DOWN  = 3'd1;
  localparam logic [2:0] OP_LEFT  = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_UNDO  = 3'd4;
  localparam logic [2:0] OP_RETRY = 3'd5;
  localparam logic [2:0] OP_NEXT  = 3'd6;
  localparam logic [2:0] OP_PREV  = 3'd7;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {LOAD_A, LOAD_B, IDLE, EXEC, CHECK, WIN} state_t;

  // Widest position field any supported grid needs; the engine packs only
  // its own POS_W bits into the stack.
  localparam int REC_POS_MAX = 16;

  typedef struct packed {
    logic [REC_POS_MAX-1:0] prev_pos;
    logic [1:0]             dir;
    logic                   pushed;
  } undo_rec_t;

  // True when a step from pos in direction dir stays on the grid.
  function automatic logic can_step(input int pos, input logic [1:0] dir,
                                    input int gw, input int gh);
    int row;
    int col;
    row = pos / gw;
    col = pos % gw;
    case (dir)
      DIR_UP:    return row > 0;
      DIR_DOWN:  return row < gh - 1;
      DIR_LEFT:  return col > 0;
      default:   return col < gw - 1;
    endcase
  endfunction

  // Linear index of the neighbouring cell; only meaningful when can_step holds.
  function automatic int neighbour(input int pos, input logic [1:0] dir, input int gw);
    case (dir)
      DIR_UP:    return pos - gw;
      DIR_DOWN:  return pos + gw;
      DIR_LEFT:  return pos - 1;
      default:   return pos + 1;
    endcase
  endfunction

endpackage

// File: rtl/sokoban_undo_stack.sv
// rtl/sokoban_undo_stack.sv - circular LIFO of move records, overwrites oldest when full
//
// Purpose: holds up to DEPTH undo records. A push when full drops the oldest
//   record and keeps count at DEPTH. rec_out always shows the newest record.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           empty the stack (level load)
//   push, pop       store rec_in / discard newest record (never both at once)
//   rec_in, rec_out record written / newest record held
//   count           number of records available
module sokoban_undo_stack #(
  parameter int DEPTH = 16,
  parameter int REC_W = 9,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [REC_W-1:0] rec_in,
  output logic [REC_W-1:0] rec_out,
  output logic [CNT_W-1:0] count
);
  import sokoban_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;

  // wr_ptr points at the next free slot; the newest record sits just below it.
  assign top_ptr = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - PTR_W'(1);
  assign rec_out = mem[top_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH))
        count <= count + CNT_W'(1);
    end else if (pop && count != '0) begin
      wr_ptr <= top_ptr;
      count  <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rec_in;
  end

endmodule

// File: rtl/sokoban_board_engine.sv
// rtl/sokoban_board_engine.sv - Sokoban board state, level load, moves, pushes, undo and win
//
// Purpose: holds the live board, loads it from the level ROM for the current
//   stage, executes move/undo/retry/stage commands and flags a win.
//   Optional macro SOKOBAN_UNDO_EN instantiates the undo history; without it
//   undo is a no-op and undo_count is tied to 0.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cmd_valid, cmd_ready, cmd_op   command handshake and op code
//   lvl_wall, lvl_box, lvl_dest    level ROM bitmaps for stage
//   lvl_man                        level ROM start position
//   wall, box, destination, man    live board
//   stage, step, undo_count, win   status
module sokoban_board_engine #(
  parameter int GRID_W     = 8,
  parameter int GRID_H     = 8,
  parameter int UNDO_DEPTH = 16,
  parameter int STEP_W     = 8,
  parameter int STAGE_W    = 2,
  localparam int CELLS     = GRID_W * GRID_H,
  localparam int POS_W     = $clog2(CELLS),
  localparam int CNT_W     = $clog2(UNDO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [CELLS-1:0]   lvl_wall,
  input  logic [CELLS-1:0]   lvl_box,
  input  logic [CELLS-1:0]   lvl_dest,
  input  logic [POS_W-1:0]   lvl_man,
  output logic [CELLS-1:0]   wall,
  output logic [CELLS-1:0]   box,
  output logic [CELLS-1:0]   destination,
  output logic [POS_W-1:0]   man,
  output logic [STAGE_W-1:0] stage,
  output logic [STEP_W-1:0]  step,
  output logic [CNT_W-1:0]   undo_count,
  output logic               win
);
  import sokoban_pkg::*;

  state_t           state;
  logic [2:0]       op_q;
  logic [1:0]       dir;
  logic             t_ok;
  logic             u_ok;
  int               t_pos;
  logic [POS_W-1:0] t_idx;
  logic [POS_W-1:0] u_idx;
  logic             push_box;
  logic             blocked;

  // Move evaluation for the latched op: t is the target, u the cell beyond it.
  always_comb begin
    dir      = op_q[1:0];
    t_ok     = can_step(int'(man), dir, GRID_W, GRID_H);
    t_pos    = neighbour(int'(man), dir, GRID_W);
    t_idx    = POS_W'(t_pos);
    u_ok     = t_ok && can_step(t_pos, dir, GRID_W, GRID_H);
    u_idx    = POS_W'(neighbour(t_pos, dir, GRID_W));
    push_box = box[t_idx];
    blocked  = !t_ok || wall[t_idx] || (push_box && (!u_ok || wall[u_idx] || box[u_idx]));
  end

`ifdef SOKOBAN_UNDO_EN
  localparam int REC_W = POS_W + 3;

  logic [REC_W-1:0] rec_out;
  logic [POS_W-1:0] rec_prev;
  logic [1:0]       rec_dir;
  logic             rec_pushed;
  logic [POS_W-1:0] b_idx;
  logic             push_rec;
  logic             pop_rec;

  assign {rec_prev, rec_dir, rec_pushed} = rec_out;
  // On undo the man stands where he was after the move, so a pushed box sits
  // one step further along the recorded direction.
  assign b_idx    = POS_W'(neighbour(int'(man), rec_dir, GRID_W));
  assign push_rec = (state == EXEC) && !op_q[2] && !blocked;
  assign pop_rec  = (state == EXEC) && (op_q == OP_UNDO) && (undo_count != '0);

  sokoban_undo_stack #(
    .DEPTH (UNDO_DEPTH),
    .REC_W (REC_W),
    .CNT_W (CNT_W)
  ) u_undo (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == LOAD_B),
    .push    (push_rec),
    .pop     (pop_rec),
    .rec_in  ({man, dir, push_box}),
    .rec_out (rec_out),
    .count   (undo_count)
  );
`else
  assign undo_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD_A;
      op_q        <= OP_UP;
      cmd_ready   <= 1'b0;
      stage       <= '0;
      step        <= '0;
      win         <= 1'b0;
      wall        <= '0;
      box         <= '0;
      destination <= '0;
      man         <= '0;
    end else begin
      case (state)
        LOAD_A: state <= LOAD_B;
        LOAD_B: begin
          wall        <= lvl_wall;
          box         <= lvl_box;
          destination <= lvl_dest;
          man         <= lvl_man;
          step        <= '0;
          win         <= 1'b0;
          cmd_ready   <= 1'b1;
          state       <= IDLE;
        end
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            cmd_ready <= 1'b0;
            state     <= EXEC;
          end
        end
        WIN: begin
          // Only level-changing ops leave the win screen; moves/undo are dropped.
          if (cmd_valid && cmd_op[2] && (cmd_op[1] || cmd_op[0])) begin
            op_q      <= cmd_op;
            cmd_ready <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (!op_q[2]) begin
            if (!blocked) begin
              man <= t_idx;
              if (push_box) begin
                box[t_idx] <= 1'b0;
                box[u_idx] <= 1'b1;
              end
              if (step != '1)
                step <= step + STEP_W'(1);
            end
            state <= CHECK;
          end else if (op_q == OP_UNDO) begin
`ifdef SOKOBAN_UNDO_EN
            if (undo_count != '0) begin
              man <= rec_prev;
              if (rec_pushed) begin
                box[b_idx] <= 1'b0;
                box[man]   <= 1'b1;
              end
              if (step != '0)
                step <= step - STEP_W'(1);
            end
            state <= CHECK;
`else
            state     <= win ? WIN : IDLE;
            cmd_ready <= 1'b1;
`endif
          end else begin
            if (op_q == OP_NEXT)
              stage <= stage + STAGE_W'(1);
            else if (op_q == OP_PREV)
              stage <= stage - STAGE_W'(1);
            step  <= '0;
            state <= LOAD_A;
          end
        end
        CHECK: begin
          win       <= ((box & ~destination) == '0) && (box != '0);
          state     <= (((box & ~destination) == '0) && (box != '0)) ? WIN : IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_sokoban_board_engine.sv
// tb/tb_sokoban_board_engine.sv - directed self-checking bench for sokoban_board_engine
module tb_sokoban_board_engine;

  localparam int CELLS = 64;
  localparam int POS_W = 6;
`ifdef SOKOBAN_UNDO_EN
  localparam bit UNDO = 1'b1;
`else
  localparam bit UNDO = 1'b0;
`endif

  localparam logic [2:0] UP = 3'd0, LEFT = 3'd2, RIGHT = 3'd3, UNDO_OP = 3'd4;
  localparam logic [2:0] RETRY = 3'd5, NEXT = 3'd6, PREV = 3'd7;
  localparam logic [63:0] ONE = 64'd1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [2:0]       cmd_op = 3'd0;
  logic [CELLS-1:0] lvl_wall = '0;
  logic [CELLS-1:0] lvl_box = '0;
  logic [CELLS-1:0] lvl_dest = '0;
  logic [POS_W-1:0] lvl_man = '0;
  logic             cmd_ready;
  logic [CELLS-1:0] wall;
  logic [CELLS-1:0] box;
  logic [CELLS-1:0] destination;
  logic [POS_W-1:0] man;
  logic [1:0]       stage;
  logic [7:0]       step;
  logic [4:0]       undo_count;
  logic             win;

  int n_cmp = 0;
  int n_err = 0;

  sokoban_board_engine dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .lvl_wall    (lvl_wall),
    .lvl_box     (lvl_box),
    .lvl_dest    (lvl_dest),
    .lvl_man     (lvl_man),
    .wall        (wall),
    .box         (box),
    .destination (destination),
    .man         (man),
    .stage       (stage),
    .step        (step),
    .undo_count  (undo_count),
    .win         (win)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready === 1'b1) break;
      tick();
    end
    check("ready_timeout", {63'd0, cmd_ready}, 64'd1);
  endtask

  // Returns 1 ns after the handshake edge.
  task automatic send(input logic [2:0] op);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic set_level(input logic [63:0] w, input logic [63:0] b,
                           input logic [63:0] d, input logic [5:0] m);
    lvl_wall = w;
    lvl_box  = b;
    lvl_dest = d;
    lvl_man  = m;
  endtask

  initial begin
    // reset state
    set_level(64'd0, ONE << 10, ONE << 11, 6'd9);
    reset = 1'b1;
    tick();
    tick();
    check("rst_man", 64'(man), 64'd0);
    check("rst_box", box, 64'd0);
    check("rst_step", 64'(step), 64'd0);
    check("rst_win", 64'(win), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_stage", 64'(stage), 64'd0);
    check("rst_undo", 64'(undo_count), 64'd0);

    // initial load
    reset = 1'b0;
    wait_ready();
    check("load_man", 64'(man), 64'd9);
    check("load_box", box, ONE << 10);
    check("load_dest", destination, ONE << 11);
    check("load_step", 64'(step), 64'd0);
    check("load_win", 64'(win), 64'd0);

    // winning push, one-cycle move latency, two-cycle win latency
    send(RIGHT);
    tick();
    check("push_man", 64'(man), 64'd10);
    check("push_box", box, ONE << 11);
    check("push_step", 64'(step), 64'd1);
    check("push_win_early", 64'(win), 64'd0);
    tick();
    check("push_win", 64'(win), 64'd1);
    check("win_ready", 64'(cmd_ready), 64'd1);
    send(UP);
    tick();
    tick();
    check("win_up_man", 64'(man), 64'd10);
    check("win_up_step", 64'(step), 64'd1);
    send(UNDO_OP);
    tick();
    tick();
    check("win_undo_man", 64'(man), 64'd10);
    check("win_undo_cnt", 64'(undo_count), UNDO ? 64'd1 : 64'd0);
    check("win_hold", 64'(win), 64'd1);

    // retry latency and wall block
    set_level(ONE << 10, 64'd0, ONE << 11, 6'd9);
    send(RETRY);
    tick();
    tick();
    check("retry_busy", 64'(cmd_ready), 64'd0);
    tick();
    check("retry_ready", 64'(cmd_ready), 64'd1);
    check("retry_wall", wall, ONE << 10);
    check("retry_man", 64'(man), 64'd9);
    check("retry_win", 64'(win), 64'd0);
    check("retry_undo", 64'(undo_count), 64'd0);
    send(RIGHT);
    wait_ready();
    check("wall_man", 64'(man), 64'd9);
    check("wall_step", 64'(step), 64'd0);
    check("wall_undo", 64'(undo_count), 64'd0);

    // box against box
    set_level(64'd0, (ONE << 10) | (ONE << 11), ONE << 12, 6'd9);
    send(RETRY);
    send(RIGHT);
    wait_ready();
    check("bb_man", 64'(man), 64'd9);
    check("bb_box", box, (ONE << 10) | (ONE << 11));

    // grid edges, no wrap
    set_level(64'd0, 64'd0, ONE << 12, 6'd0);
    send(RETRY);
    send(LEFT);
    wait_ready();
    check("edge_left", 64'(man), 64'd0);
    check("edge_step", 64'(step), 64'd0);
    send(UP);
    wait_ready();
    check("edge_up", 64'(man), 64'd0);

    // push then undo
    set_level(64'd0, ONE << 10, ONE << 20, 6'd9);
    send(RETRY);
    send(RIGHT);
    wait_ready();
    check("u_push_man", 64'(man), 64'd10);
    check("u_push_cnt", 64'(undo_count), UNDO ? 64'd1 : 64'd0);
    send(UNDO_OP);
    wait_ready();
    check("undo_man", 64'(man), UNDO ? 64'd9 : 64'd10);
    check("undo_box", box, UNDO ? (ONE << 10) : (ONE << 11));
    check("undo_step", 64'(step), UNDO ? 64'd0 : 64'd1);
    check("undo_cnt", 64'(undo_count), 64'd0);

    // 20 moves overflow the 16-deep history
    set_level(64'd0, 64'd0, ONE << 20, 6'd0);
    send(RETRY);
    for (int i = 0; i < 20; i++) send((i % 2 == 0) ? RIGHT : LEFT);
    wait_ready();
    check("m20_man", 64'(man), 64'd0);
    check("m20_step", 64'(step), 64'd20);
    check("m20_cnt", 64'(undo_count), UNDO ? 64'd16 : 64'd0);
    for (int i = 0; i < 15; i++) send(UNDO_OP);
    wait_ready();
    check("u15_man", 64'(man), UNDO ? 64'd1 : 64'd0);
    check("u15_cnt", 64'(undo_count), UNDO ? 64'd1 : 64'd0);
    send(UNDO_OP);
    wait_ready();
    check("u16_man", 64'(man), 64'd0);
    check("u16_step", 64'(step), UNDO ? 64'd4 : 64'd20);
    send(UNDO_OP);
    wait_ready();
    check("u17_man", 64'(man), 64'd0);
    check("u17_step", 64'(step), UNDO ? 64'd4 : 64'd20);
    check("u17_cnt", 64'(undo_count), 64'd0);

    // stage wrap both ways
    send(PREV);
    wait_ready();
    check("prev_stage", 64'(stage), 64'd3);
    check("prev_step", 64'(step), 64'd0);
    set_level(64'd0, ONE << 10, ONE << 20, 6'd9);
    send(NEXT);
    wait_ready();
    check("next_stage", 64'(stage), 64'd0);
    check("next_man", 64'(man), 64'd9);
    check("next_box", box, ONE << 10);
    check("next_step", 64'(step), 64'd0);

    // reset while EXEC is pending
    send(NEXT);
    wait_ready();
    check("s1_stage", 64'(stage), 64'd1);
    send(RIGHT);
    reset = 1'b1;
    tick();
    check("mid_rst_man", 64'(man), 64'd0);
    check("mid_rst_box", box, 64'd0);
    check("mid_rst_stage", 64'(stage), 64'd0);
    check("mid_rst_ready", 64'(cmd_ready), 64'd0);
    check("mid_rst_step", 64'(step), 64'd0);
    reset = 1'b0;
    wait_ready();
    check("post_rst_man", 64'(man), 64'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
